// File: rtl/fp8_mul_arbiter.sv
// Two-requester round-robin front end for a shared FP8VectorMul2 pipeline: in-order
// result routing by tag, per-requester FWFT response FIFOs, credit flow control and mode draining.
module fp8_mul_arbiter #(
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req_e5m2,
    input  logic [79:0]  req_data,
    output logic         mul_in_valid,
    output logic         mul_e5m2mode,
    output logic [7:0]   mul_q,
    output logic [7:0]   mul_k,
    output logic [7:0]   mul_a,
    output logic [7:0]   mul_b,
    output logic [7:0]   mul_c,
    input  logic         mul_out_valid,
    input  logic [95:0]  mul_res,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [191:0] rsp_data,
    output logic         draining,
    output logic         err
);

    localparam int unsigned RAW = $clog2(RSP_DEPTH);
    localparam int unsigned TAW = $clog2(TAG_DEPTH);

    typedef logic [RAW-1:0] rptr_t;
    typedef logic [RAW:0]   rcnt_t;
    typedef logic [TAW-1:0] tptr_t;
    typedef logic [TAW:0]   tcnt_t;
    typedef enum logic {RUN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic                 cur_mode, rr_last;
    logic [TAG_DEPTH-1:0] tag_mem;
    tptr_t                tag_wp, tag_rp;
    tcnt_t                tag_cnt;
    rcnt_t                credit  [2];
    logic [95:0]          rsp_mem [2][RSP_DEPTH];
    rptr_t                rsp_wp  [2];
    rptr_t                rsp_rp  [2];
    rcnt_t                rsp_cnt [2];

    logic [1:0] elig, grant, rsp_push, rsp_pop;
    logic       win, other, any_elig, issue, stall;
    logic       tag_empty, tag_full, res_push, res_tag;

    always_comb begin
        tag_empty = (tag_cnt == '0);
        tag_full  = (tag_cnt == tcnt_t'(TAG_DEPTH));
        for (int unsigned i = 0; i < 2; i++) begin
            elig[i] = req_valid[i] && (credit[i] != '0) && !tag_full;
        end
        any_elig = |elig;
        other    = ~rr_last;
        win      = elig[other] ? other : rr_last;
        // A mode-mismatched winner blocks both requesters until the pipeline is empty.
        issue    = rst && any_elig && ((req_e5m2[win] == cur_mode) || tag_empty);
        stall    = rst && any_elig && !issue;
        grant    = '0;
        if (issue) grant[win] = 1'b1;

        state_d = state_q;
        if (issue)      state_d = RUN;
        else if (stall) state_d = DRAIN;

        res_push = mul_out_valid && !tag_empty;
        res_tag  = tag_mem[tag_rp];
        rsp_data = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            rsp_valid[i] = (rsp_cnt[i] != '0);
            rsp_pop[i]   = rsp_valid[i] && rsp_ready[i];
            rsp_push[i]  = res_push && (res_tag == 1'(i));
            if (rsp_valid[i]) rsp_data[96*i +: 96] = rsp_mem[i][rsp_rp[i]];
        end
    end

    assign req_ready = grant;
    assign draining  = (state_q == DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            cur_mode     <= 1'b0;
            rr_last      <= 1'b1;
            mul_in_valid <= 1'b0;
            mul_e5m2mode <= 1'b0;
            {mul_q, mul_k, mul_a, mul_b, mul_c} <= '0;
            tag_mem      <= '0;
            tag_wp       <= '0;
            tag_rp       <= '0;
            tag_cnt      <= '0;
            err          <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                credit[i]  <= rcnt_t'(RSP_DEPTH);
                rsp_wp[i]  <= '0;
                rsp_rp[i]  <= '0;
                rsp_cnt[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            mul_in_valid <= issue;
            if (issue) begin
                {mul_q, mul_k, mul_a, mul_b, mul_c} <= win ? req_data[79:40] : req_data[39:0];
                mul_e5m2mode     <= req_e5m2[win];
                cur_mode         <= req_e5m2[win];
                rr_last          <= win;
                tag_mem[tag_wp]  <= win;
                tag_wp           <= tag_wp + tptr_t'(1);
            end
            if (res_push) tag_rp <= tag_rp + tptr_t'(1);
            if (issue && !res_push)      tag_cnt <= tag_cnt + tcnt_t'(1);
            else if (!issue && res_push) tag_cnt <= tag_cnt - tcnt_t'(1);
            if (mul_out_valid && tag_empty) err <= 1'b1;

            // Credits cover both queued and in-flight results, so a result moving
            // from the pipeline into its FIFO leaves the credit untouched.
            for (int unsigned i = 0; i < 2; i++) begin
                if (grant[i] && !rsp_pop[i])      credit[i] <= credit[i] - rcnt_t'(1);
                else if (!grant[i] && rsp_pop[i]) credit[i] <= credit[i] + rcnt_t'(1);
                if (rsp_push[i]) rsp_wp[i] <= rsp_wp[i] + rptr_t'(1);
                if (rsp_pop[i])  rsp_rp[i] <= rsp_rp[i] + rptr_t'(1);
                if (rsp_push[i] && !rsp_pop[i])      rsp_cnt[i] <= rsp_cnt[i] + rcnt_t'(1);
                else if (!rsp_push[i] && rsp_pop[i]) rsp_cnt[i] <= rsp_cnt[i] - rcnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (rsp_push[i]) rsp_mem[i][rsp_wp[i]] <= mul_res;
        end
    end

endmodule

// File: doc/fp8_mul_arbiter.md
Name: fp8_mul_arbiter

Overview:
- Shares one FP8VectorMul2 pipeline between two requesters.
- Grants requests round-robin and drives the multiplier's input bus.
- Tracks in-flight ops with a tag FIFO and routes each result to its requester's response FIFO.
- Serialises E4M3/E5M2 mode changes by draining the pipeline before switching e5m2mode.

Parameters:
- RSP_DEPTH, 4: entries per requester response FIFO (power of 2, ≥2).
- TAG_DEPTH, 8: max in-flight ops (power of 2); must be ≥ multiplier latency + 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted, one-hot or zero.
- req_e5m2  in  2  per-requester mode: 1 = E5M2, 0 = E4M3.
- req_data  in  80  requester i at [40i+39:40i], packed {q,k,a,b,c}, q in MSBs.
- mul_in_valid  out  1  to multiplier in_valid.
- mul_e5m2mode  out  1  to multiplier e5m2mode.
- mul_q, mul_k, mul_a, mul_b, mul_c  out  8 each  multiplier operands.
- mul_out_valid  in  1  from multiplier out_valid.
- mul_res  in  96  packed {qa,qb,qc,ka,kb,kc} from multiplier.
- rsp_valid  out  2  response FIFO i non-empty.
- rsp_ready  in  2  response pop, per requester.
- rsp_data  out  192  FIFO i head at [96i+95:96i].
- draining  out  1  stalled for a mode switch.
- err  out  1  sticky: result arrived with tag FIFO empty.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; cur_mode=0 (E4M3); rr_last=1, so requester 0 has first priority.
  - Tag FIFO and response FIFOs empty; credit[i]=RSP_DEPTH; state RUN.
- Eligibility: elig[i] = req_valid[i] && credit[i]>0 && tag FIFO not full.
- Winner: W is the eligible requester ≠ rr_last if that requester is eligible, else the other eligible requester; if none is eligible, no winner.
- Issue rule: issue the winner when req_e5m2[W]==cur_mode or inflight==0.
  - If W's mode mismatches and inflight>0: no issue, no bypass by the other requester. State goes to DRAIN and draining=1.
  - Return to RUN on the cycle W issues.
- req_ready[W]=1 combinationally on issue. It depends on req_valid; requesters must not wait for ready before asserting valid.
- On issue (registered, next cycle):
  - mul_in_valid=1, operands = req_data slice, mul_e5m2mode = req_e5m2[W].
  - cur_mode <= req_e5m2[W]; rr_last <= W; push W to tag FIFO; credit[W]--.
- Without issue: mul_in_valid=0. Operands and mul_e5m2mode hold their last values.
- Result handling: the multiplier is strictly in-order.
  - On mul_out_valid: pop the tag, push mul_res into the response FIFO selected by the tag.
  - If mul_out_valid arrives with the tag FIFO empty: drop the result, set err=1 until reset.
- inflight = tag FIFO count. Simultaneous push and pop leaves the count unchanged.
- Response FIFO: first-word-fall-through.
  - rsp_valid[i] = non-empty; rsp_data slice = head entry.
  - Pop on rsp_valid[i] && rsp_ready[i]; push lands registered.
- Credits: credit[i] = RSP_DEPTH − occupancy − in-flight for i.
  - Issue to i and pop by i in the same cycle: net unchanged.
  - Consequence: response FIFOs never overflow and no result is ever dropped for lack of space.
- Latency with FP8VectorMul2 (2 stages): handshake at edge t → mul_in_valid at t+1 → mul_out_valid at t+3 → rsp_valid at t+4.
- Throughput: 1 op/clock when both requesters use the same mode and credits are available.
- Mid-operation reset: all in-flight state is discarded. The multiplier shares rst, so no stale results return; any that do set err.

Test Plan:
1. Single requester, E4M3: req0 sends q=0x38, k=0x4C, a=0xC4, b=0x40, c=0xC8 → mul_in_valid 1 cycle after handshake; rsp_valid[0] 4 cycles after handshake; rsp_data[95:0] equals the multiplier's qa..kc; rsp_valid[1] stays 0.
2. Both requesters stream 8 ops each, same mode, rsp_ready=11 → grants alternate 0,1,0,1…; one issue per cycle; each requester gets its own 8 results in order with payloads matching.
3. Backpressure: rsp_ready[0]=0, req0 streams → exactly 4 (RSP_DEPTH) req0 issues, then req_ready[0]=0 while req1 still issues; raising rsp_ready resumes req0 with no loss.
4. Mode switch: req0 E4M3 in flight, req1 E5M2 → draining=1 until inflight=0; req1 issues with mul_e5m2mode=1; draining drops that cycle; req0 is not granted during the drain.
5. Reset with 3 ops in flight: rst=0 for 2 cycles → all outputs 0, credits restored to 4, err=0; the next request completes normally.
6. Spurious mul_out_valid forced with the tag FIFO empty → err=1 and sticky; no rsp_valid asserted.
